muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//   Multi-cycle RV64M multiply/divide sequencer beside the execute-stage ALU.
//   Latches operands, runs iterative shift-add multiply or restoring divide, applies sign fixup and W-variant sign extension.
//   Raises a stall request to hold execute until the result is ready.
//   Holds the result until the pipeline acknowledges it; a flush aborts the operation.
// PARAMETERS
//   XLEN     64             operand/result width (only 64 supported)
//   CNT_W    $clog2(XLEN)+1 iteration counter width
// PORTS
//   clk       in   1     clock; all state changes on posedge
//   reset     in   1     synchronous, active-high reset
//   valid_i   in   1     execute holds a muldiv instr; held high while stalled
//   op_i      in   4     0000 MUL, 0001 DIV, 0010 DIVU, 0011 REM, 0100 REMU; bit3=1 selects the W form of the same op
//   src1_i    in   64    forwarded rs1 value
//   src2_i    in   64    forwarded rs2 value
//   ack_i     in   1     execute advances this cycle (consumes result)
//   flush_i   in   1     squash in-flight op (branch/exception redirect)
//   busy_o    out  1     stall request to execute (combinational)
//   done_o    out  1     result_o valid
//   result_o  out  64    final result
// BEHAVIOUR
//   Reset: state=IDLE, done_o=0, result_o=0, counter=0, operand regs=0.
//   States: IDLE, MUL, DIV, FIX, DONE.
//   Accept (cycle 0): in IDLE with valid_i && !flush_i, latch operands.
//     W signed ops: sign-extend src[31:0]. DIVUW/REMUW: zero-extend src[31:0].
//     Signed div/rem: divide magnitudes; record quotient sign and dividend sign.
//   Special cases go straight to DONE at cycle 1:
//     Divisor 0: quotient=all ones; remainder=dividend.
//     Signed overflow (min / -1, 64- or 32-bit per op): quotient=dividend; remainder=0.
//   MUL: 64 shift-add iterations over cycles 1..64; low 64 product bits; DONE at cycle 65.
//   DIV: 64 restoring iterations over cycles 1..64; FIX (negate per signs) at cycle 65; DONE at cycle 66.
//   Illegal op code: result 0, DONE at cycle 1.
//   W forms: result_o = sign-extend(result[31:0]); applies to special cases too.
//   busy_o = (state in MUL/DIV/FIX) || (state==IDLE && valid_i && !flush_i); 0 in DONE.
//   done_o=1 only in DONE; result_o stable for the whole DONE interval.
//   DONE->IDLE on ack_i; ack_i outside DONE is ignored.
//   Next op can be accepted the cycle after ack.
//   flush_i has priority over everything: any state -> IDLE next cycle, done_o=0, no result.
//     Flush in the accept cycle suppresses the accept.
//   valid_i dropping mid-operation is ignored; the op completes and waits in DONE.
//   reset mid-operation: same as reset.
//   Counter counts iterations 0..63; a terminal count ends MUL/DIV; no wrap past 63.
// CONFIGURATION
//   MULDIV_FAST_MUL_EN defined:
//     MUL/MULW compute single-cycle (combinational 64x64 low product into register); DONE at cycle 1.
//     MUL state unused.
//   Undefined: iterative 64-cycle multiply as above.
//   Divide timing is identical either way.
// TESTING
//   Reset 3 cycles, valid_i=1 -> done_o=0, result_o=0, state IDLE during reset.
//   DIV 100 / -7 -> busy_o=1 cycles 0..65; done_o at 66 with 0xFFFFFFFFFFFFFFF2.
//   REM -100,7 -> 0xFFFFFFFFFFFFFFFE.
//   REMU 0x1234 / 0 -> 0x1234 at cycle 1.
//   DIV 0x8000000000000000 / -1 -> 0x8000000000000000 at cycle 1.
//   DIVW src1=0x0000000080000000, src2=-1 -> 0xFFFFFFFF80000000 at cycle 1.
//   MULW 0x7FFFFFFF * 2 -> 0xFFFFFFFFFFFFFFFE at cycle 65 (cycle 1 with MULDIV_FAST_MUL_EN).
//   DIVU flushed at cycle 30 -> IDLE at 31, done_o never asserts; new MUL accepted at 31 completes normally.
//   ack_i low 5 cycles in DONE -> done_o/result_o held; ack_i=1 -> done_o=0 next cycle.

Source files
------------

// File: rtl/muldiv_if.sv
// Execute-stage handshake bundle for the multi-cycle RV64M mul/div sequencer.
// master = execute stage, slave = sequencer.
interface muldiv_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic [3:0]      op_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            ack_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, op_i, src1_i, src2_i, ack_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  valid_i, op_i, src1_i, src2_i, ack_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV64M mul/div sequencer: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              rem_q, rem_d;
    logic              w_q, w_d;
    logic              busy;

    function automatic logic [XLEN-1:0] sext_w(
        input logic w, input logic [XLEN-1:0] v
    );
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    logic [2:0]      op_f;
    logic            op_w;
    logic            is_mul, is_div, is_sgn, is_uns, is_rem;
    logic [XLEN-1:0] s1, s2, mag1, mag2, spec_res;
    logic            div0, ovf;

    always_comb begin
        op_f   = bus.op_i[2:0];
        op_w   = bus.op_i[3];
        is_mul = (op_f == 3'd0);
        is_div = (op_f >= 3'd1) && (op_f <= 3'd4);
        is_sgn = (op_f == 3'd1) || (op_f == 3'd3);
        is_uns = (op_f == 3'd2) || (op_f == 3'd4);
        is_rem = (op_f == 3'd3) || (op_f == 3'd4);
        s1 = bus.src1_i;
        s2 = bus.src2_i;
        if (op_w) begin
            s1 = is_uns ? {{(XLEN-32){1'b0}}, bus.src1_i[31:0]}
                        : {{(XLEN-32){bus.src1_i[31]}}, bus.src1_i[31:0]};
            s2 = is_uns ? {{(XLEN-32){1'b0}}, bus.src2_i[31:0]}
                        : {{(XLEN-32){bus.src2_i[31]}}, bus.src2_i[31:0]};
        end
        div0 = (s2 == '0);
        ovf  = is_sgn && (s2 == '1) &&
               (op_w ? (s1[31:0] == 32'h8000_0000) : (s1 == MIN_VAL));
        mag1 = (is_sgn && s1[XLEN-1]) ? -s1 : s1;
        mag2 = (is_sgn && s2[XLEN-1]) ? -s2 : s2;
        if (div0)
            spec_res = is_rem ? s1 : '1;
        else
            spec_res = is_rem ? '0 : s1;
    end

    // One iteration of each datapath, evaluated from the current registers
    logic [XLEN-1:0] mul_add;
    logic [XLEN:0]   rem_sh, diff;
    logic            q_bit;
    logic [XLEN-1:0] div_acc, div_quo, fix_val;

    always_comb begin
        mul_add = opb_q[0] ? acc_q + opa_q : acc_q;
        rem_sh  = {acc_q, opa_q[XLEN-1]};
        diff    = rem_sh - {1'b0, opb_q};
        q_bit   = ~diff[XLEN];
        div_acc = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        div_quo = {opa_q[XLEN-2:0], q_bit};
        if (rem_q)
            fix_val = negr_q ? -acc_q : acc_q;
        else
            fix_val = negq_q ? -opa_q : opa_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        res_d   = res_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        rem_d   = rem_q;
        w_d     = w_q;
        busy    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.valid_i && !bus.flush_i) begin
                    busy   = 1'b1;
                    w_d    = op_w;
                    rem_d  = is_rem;
                    negq_d = is_sgn & (s1[XLEN-1] ^ s2[XLEN-1]);
                    negr_d = is_sgn & s1[XLEN-1];
                    cnt_d  = '0;
                    acc_d  = '0;
                    if (is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                        res_d   = sext_w(op_w, s1 * s2);
                        state_d = S_DONE;
`else
                        opa_d   = s1;
                        opb_d   = s2;
                        state_d = S_MUL;
`endif
                    end else if (is_div) begin
                        if (div0 || ovf) begin
                            res_d   = sext_w(op_w, spec_res);
                            state_d = S_DONE;
                        end else begin
                            opa_d   = mag1;
                            opb_d   = mag2;
                            state_d = S_DIV;
                        end
                    end else begin
                        res_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                busy  = 1'b1;
                acc_d = mul_add;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = sext_w(w_q, mul_add);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                busy  = 1'b1;
                acc_d = div_acc;
                opa_d = div_quo;
                if (cnt_q == CNT_LAST)
                    state_d = S_FIX;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
                busy    = 1'b1;
                res_d   = sext_w(w_q, fix_val);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.ack_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.flush_i)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            rem_q   <= 1'b0;
            w_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            rem_q   <= rem_d;
            w_q     <= w_d;
        end
    end

    assign bus.busy_o   = busy;
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.result_o = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model plus
// directed vectors with hand-computed results and latencies.
module tb_muldiv_seq;

    bit   clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(64)) bus ();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 65;
`endif
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] ext(logic [3:0] op, logic [63:0] v);
        if (!op[3])
            return v;
        if (op[2:0] == 3'd2 || op[2:0] == 3'd4)
            return {32'b0, v[31:0]};
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic [63:0] ref_res(logic [3:0] op,
                                            logic [63:0] a,
                                            logic [63:0] b);
        logic [63:0] x, y, r;
        longint      sx, sy;
        logic        ov;
        x  = ext(op, a);
        y  = ext(op, b);
        sx = x;
        sy = y;
        ov = (x == MIN64) && (y == '1);
        r  = '0;
        case (op[2:0])
            3'd0: r = x * y;
            3'd1: begin
                if (y == 0)  r = '1;
                else if (ov) r = x;
                else         r = 64'(sx / sy);
            end
            3'd2: begin
                if (y == 0) r = '1;
                else        r = x / y;
            end
            3'd3: begin
                if (y == 0)  r = x;
                else if (ov) r = '0;
                else         r = 64'(sx % sy);
            end
            3'd4: begin
                if (y == 0) r = x;
                else        r = x % y;
            end
            default: r = '0;
        endcase
        if (op[3])
            r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    function automatic int lat_of(logic [3:0] op,
                                  logic [63:0] a,
                                  logic [63:0] b);
        logic [63:0] x, y;
        logic        sgn, ov;
        if (op[2:0] > 3'd4)
            return 1;
        if (op[2:0] == 3'd0)
            return MUL_LAT;
        x   = ext(op, a);
        y   = ext(op, b);
        sgn = (op[2:0] == 3'd1) || (op[2:0] == 3'd3);
        ov  = sgn && (y == '1) &&
              (op[3] ? (x == 64'hFFFF_FFFF_8000_0000) : (x == MIN64));
        if (y == 0 || ov)
            return 1;
        return 66;
    endfunction

    // Reference model: cycles since accept, result released at its latency
    bit          m_known    = 1'b0;
    bit          m_inflight = 1'b0;
    bit          m_done     = 1'b0;
    int          m_cyc      = 0;
    int          m_lat      = 0;
    logic [63:0] m_res      = '0;
    logic [63:0] m_pend     = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_known    <= 1'b1;
            m_inflight <= 1'b0;
            m_done     <= 1'b0;
            m_res      <= '0;
        end else if (bus.flush_i) begin
            m_inflight <= 1'b0;
            m_done     <= 1'b0;
        end else if (m_done) begin
            if (bus.ack_i)
                m_done <= 1'b0;
        end else if (m_inflight) begin
            m_cyc <= m_cyc + 1;
            if (m_cyc + 1 == m_lat) begin
                m_inflight <= 1'b0;
                m_done     <= 1'b1;
                m_res      <= m_pend;
            end
        end else if (bus.valid_i) begin
            m_pend <= ref_res(bus.op_i, bus.src1_i, bus.src2_i);
            m_lat  <= lat_of(bus.op_i, bus.src1_i, bus.src2_i);
            m_cyc  <= 1;
            if (lat_of(bus.op_i, bus.src1_i, bus.src2_i) == 1) begin
                m_done <= 1'b1;
                m_res  <= ref_res(bus.op_i, bus.src1_i, bus.src2_i);
            end else begin
                m_inflight <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("busy", 64'(bus.busy_o),
                64'(m_inflight ||
                    (!m_done && bus.valid_i && !bus.flush_i)));
            chk("done", 64'(bus.done_o), 64'(m_done));
            if (m_done)
                chk("result", bus.result_o, m_res);
        end
    end

    task automatic do_op(string nm, logic [3:0] op,
                         logic [63:0] a, logic [63:0] b,
                         logic [63:0] exp, int lat,
                         int hold, bit drop);
        int cyc;
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
        cyc = 0;
        while (!bus.done_o && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (drop && cyc == 3)
                bus.valid_i = 1'b0;
        end
        chk({nm, "_lat"}, 64'(cyc), 64'(lat));
        chk({nm, "_res"}, bus.result_o, exp);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk({nm, "_hold"}, bus.result_o, exp);
        end
        bus.ack_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ack_i   = 1'b0;
        bus.valid_i = 1'b0;
        chk({nm, "_ack"}, 64'(bus.done_o), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        bus.valid_i = 1'b1;
        bus.op_i    = 4'b0001;
        bus.src1_i  = 64'd100;
        bus.src2_i  = 64'd3;
        bus.ack_i   = 1'b0;
        bus.flush_i = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_done", 64'(bus.done_o), 64'd0);
            chk("rst_res", bus.result_o, 64'd0);
        end
        bus.valid_i = 1'b0;
        reset       = 1'b0;
        @(posedge clk);
        #1;

        do_op("div_100_m7", 4'b0001, 64'd100, -64'sd7,
              64'hFFFF_FFFF_FFFF_FFF2, 66, 0, 1'b0);
        do_op("rem_m100_7", 4'b0011, -64'sd100, 64'd7,
              64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 1'b1);
        do_op("remu_div0", 4'b0100, 64'h1234, 64'd0,
              64'h1234, 1, 0, 1'b0);
        do_op("div_ovf", 4'b0001, MIN64, '1,
              MIN64, 1, 0, 1'b0);
        do_op("divw_ovf", 4'b1001, 64'h0000_0000_8000_0000, '1,
              64'hFFFF_FFFF_8000_0000, 1, 0, 1'b0);
        do_op("mulw", 4'b1000, 64'h7FFF_FFFF, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT, 0, 1'b0);
        do_op("mul_neg", 4'b0000, -64'sd3, 64'd7,
              64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, 0, 1'b0);
        do_op("divu_hold", 4'b0010, 64'd1000, 64'd7,
              64'h8E, 66, 5, 1'b0);
        do_op("remw", 4'b1011, -64'sd100, 64'd7,
              64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 1'b0);
        do_op("divuw", 4'b1010, 64'hFFFF_FFF0_FFFF_FFFF, 64'd2,
              64'h7FFF_FFFF, 66, 0, 1'b0);
        do_op("remuw_div0", 4'b1100, 64'h1_8000_0005, 64'h5_0000_0000,
              64'hFFFF_FFFF_8000_0005, 1, 0, 1'b0);
        do_op("illegal", 4'b0101, 64'd9, 64'd3,
              64'd0, 1, 0, 1'b0);
        do_op("div_0", 4'b0001, 64'd7, 64'd0,
              '1, 1, 0, 1'b0);
        do_op("rem_ovf", 4'b0011, MIN64, '1,
              64'd0, 1, 0, 1'b0);

        // Flush in the accept cycle suppresses the op
        bus.valid_i = 1'b1;
        bus.op_i    = 4'b0001;
        bus.src1_i  = 64'd50;
        bus.src2_i  = 64'd5;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("flush_acc_done", 64'(bus.done_o), 64'd0);

        // DIVU flushed at cycle 30, stray ack ignored, MUL accepted at 31
        bus.valid_i = 1'b1;
        bus.op_i    = 4'b0010;
        bus.src1_i  = 64'd1000;
        bus.src2_i  = 64'd7;
        bus.ack_i   = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        bus.ack_i   = 1'b0;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        chk("flush_idle", 64'(bus.done_o), 64'd0);
        do_op("mul_after_flush", 4'b0000, 64'h1_0000_0003, 64'd5,
              64'h5_0000_000F, MUL_LAT, 0, 1'b0);

        // Reset in the middle of a divide
        bus.valid_i = 1'b1;
        bus.op_i    = 4'b0001;
        bus.src1_i  = 64'd100;
        bus.src2_i  = 64'd7;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.valid_i = 1'b0;
        chk("midrst_done", 64'(bus.done_o), 64'd0);
        chk("midrst_res", bus.result_o, 64'd0);
        @(posedge clk);
        #1;
        do_op("div_after_rst", 4'b0001, 64'd100, 64'd7,
              64'd14, 66, 2, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
